// File: rtl/f1_light_seq.sv
// -----------------------------------------------------------------------------
// f1_light_seq
//
// Start-light sequencer. A trigger in IDLE starts a sequence: one lamp per
// tick strobe lights (thermometer, bit 0 first) until all N_LIGHTS are lit,
// all lamps stay lit for hold_ticks+1 further ticks, then every lamp goes out
// together with a one-clock go pulse. In auto-repeat mode the sequence
// restarts straight after go with the hold length captured at the trigger.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   en           tick strobe, one clk wide; FILL and HOLD advance only on it
//   trigger      start request, honoured only in IDLE
//   repeat_mode  0 = one-shot, 1 = auto-repeat (sampled at HOLD exit)
//   hold_ticks   hold length, captured when the trigger is accepted
//   data_out     lamp vector, thermometer coded
//   busy         high while in FILL or HOLD
//   go           one-clk pulse in the cycle the lamps go out
// -----------------------------------------------------------------------------
module f1_light_seq #(
    parameter int N_LIGHTS = 8,
    parameter int HOLD_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                trigger,
    input  logic                repeat_mode,
    input  logic [HOLD_W-1:0]   hold_ticks,
    output logic [N_LIGHTS-1:0] data_out,
    output logic                busy,
    output logic                go
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_HOLD
    } state_t;

    state_t              r_state,    w_state_nxt;
    logic [N_LIGHTS-1:0] r_data,     w_data_nxt;
    logic                r_busy,     w_busy_nxt;
    logic                r_go,       w_go_nxt;
    logic [HOLD_W-1:0]   r_hold_cnt, w_hold_cnt_nxt;
    logic [HOLD_W-1:0]   r_hold_cap, w_hold_cap_nxt;

    // Lamp vector after one more FILL tick; all ones here means FILL is done.
    logic [N_LIGHTS-1:0] w_data_shift;
    assign w_data_shift = {r_data[N_LIGHTS-2:0], 1'b1};

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others; blocking here would create ordering
    // dependent simulation and a mismatch against synthesis.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_data     <= '0;
            r_busy     <= 1'b0;
            r_go       <= 1'b0;
            r_hold_cnt <= '0;
            r_hold_cap <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_data     <= w_data_nxt;
            r_busy     <= w_busy_nxt;
            r_go       <= w_go_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
            r_hold_cap <= w_hold_cap_nxt;
        end
    end

    // NOTE: every signal written below gets a default first, so no path can
    // leave it unassigned and infer a latch. The defaults also make en=0 a
    // freeze of all state, while go falls back to 0 after its single cycle.
    always_comb begin
        w_state_nxt    = r_state;
        w_data_nxt     = r_data;
        w_go_nxt       = 1'b0;
        w_hold_cnt_nxt = r_hold_cnt;
        w_hold_cap_nxt = r_hold_cap;

        case (r_state)
            ST_IDLE: begin
                w_data_nxt = '0;
                // en is deliberately not looked at: the first lamp must wait
                // for a strobe strictly after the accepting edge.
                if (trigger) begin
                    w_hold_cap_nxt = hold_ticks;
                    w_hold_cnt_nxt = hold_ticks;
                    w_state_nxt    = ST_FILL;
                end
            end

            ST_FILL: begin
                if (en) begin
                    w_data_nxt = w_data_shift;
                    if (&w_data_shift) begin
                        w_state_nxt = ST_HOLD;
                    end
                end
            end

            ST_HOLD: begin
                if (en) begin
                    if (r_hold_cnt == '0) begin
                        w_data_nxt = '0;
                        w_go_nxt   = 1'b1;
                        if (repeat_mode) begin
                            // Reload from the trigger-time capture, not the
                            // live input, so mid-sequence changes are ignored.
                            w_hold_cnt_nxt = r_hold_cap;
                            w_state_nxt    = ST_FILL;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end else begin
                        w_hold_cnt_nxt = r_hold_cnt - 1'b1;
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_data_nxt  = '0;
            end
        endcase

        // busy is registered alongside the state it describes.
        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    assign data_out = r_data;
    assign busy     = r_busy;
    assign go       = r_go;

endmodule

// File: tb/tb_f1_light_seq.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_f1_light_seq
//
// A reference model counts strobe ticks since the start of each sequence and
// derives the lamp pattern, busy and go from that count arithmetically. Each
// clock edge it queues the expected outputs; a monitor on the falling edge
// pops one entry and compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_f1_light_seq;

    localparam int N  = 8;
    localparam int HW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          trigger;
    logic          repeat_mode;
    logic [HW-1:0] hold_ticks;
    logic [N-1:0]  data_out;
    logic          busy;
    logic          go;

    f1_light_seq #(.N_LIGHTS(N), .HOLD_W(HW)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .trigger     (trigger),
        .repeat_mode (repeat_mode),
        .hold_ticks  (hold_ticks),
        .data_out    (data_out),
        .busy        (busy),
        .go          (go)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- model
    typedef struct packed {
        logic [N-1:0] data;
        logic         busy;
        logic         go;
    } exp_t;

    exp_t exp_q[$];
    bit   m_act = 1'b0;   // a sequence is running
    int   m_t   = 0;      // en ticks since the sequence (re)started
    int   m_h   = 0;      // hold length captured at trigger
    int   m_go  = 0;
    exp_t m_e;

    // Thermometer pattern after t ticks: t lamps lit, saturating at all N.
    function automatic logic [N-1:0] lamps(input int t);
        logic [63:0] v;
        if (t >= N) return '1;
        v = (64'd1 << t) - 64'd1;
        return v[N-1:0];
    endfunction

    always @(posedge clk) begin
        m_e.go = 1'b0;
        if (rst) begin
            m_act = 1'b0;
            m_t   = 0;
        end else if (!m_act) begin
            if (trigger) begin
                m_act = 1'b1;
                m_t   = 0;
                m_h   = int'(hold_ticks);
            end
        end else if (en) begin
            m_t++;
            // N fill ticks plus h+1 hold ticks, the last of which is go.
            if (m_t == N + m_h + 1) begin
                m_e.go = 1'b1;
                m_go++;
                m_t = 0;
                if (!repeat_mode) m_act = 1'b0;
            end
        end
        m_e.busy = m_act;
        m_e.data = m_act ? lamps(m_t) : '0;
        exp_q.push_back(m_e);
    end

    // -------------------------------------------------------------- monitor
    int   dut_go = 0;
    exp_t got;

    always @(negedge clk) begin
        if (exp_q.size() == 0) begin
            check("queue_underflow", 64'd0, 64'd1);
        end else begin
            got = exp_q.pop_front();
            check("data_out", 64'(data_out), 64'(got.data));
            check("busy",     64'(busy),     64'(got.busy));
            check("go",       64'(go),       64'(got.go));
            if (go === 1'b1) dut_go++;
        end
    end

    // ------------------------------------------------------------- stimulus
    int cyc     = 0;
    int en_per  = 1;
    bit en_rand = 1'b0;

    task automatic step(input int n, input bit trig = 1'b0, input bit r = 1'b0);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            rst     = r;
            trigger = trig;
            if (en_rand) en = ($urandom_range(0, 3) == 0);
            else         en = ((cyc % en_per) == 0);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; trigger = 1'b0;
        repeat_mode = 1'b0; hold_ticks = '0;

        // Reset, then idle with en toggling and no trigger.
        step(3, 1'b0, 1'b1);
        en_per = 2;
        step(20);

        // hold 3, en every 4th cycle, single trigger.
        en_per = 4; hold_ticks = 8'd3;
        step(1, 1'b1);
        step(60);

        // trigger coincident with en in IDLE, hold 0, back-to-back en.
        en_per = 1; hold_ticks = 8'd0;
        step(1, 1'b1);
        step(15);

        // Extra triggers and hold_ticks changes during a sequence.
        en_per = 2; hold_ticks = 8'd4;
        step(1, 1'b1);
        for (int i = 0; i < 24; i++) begin
            step(1, ($urandom_range(0, 2) == 0));
            hold_ticks = HW'($urandom_range(0, 200));
        end
        step(10);

        // Auto-repeat with hold 2, then drop repeat_mode.
        en_per = 2; hold_ticks = 8'd2; repeat_mode = 1'b1;
        step(1, 1'b1);
        step(60);
        repeat_mode = 1'b0;
        step(40);

        // Reset mid-FILL (three lamps lit), then a full fresh sequence.
        en_per = 1; hold_ticks = 8'd5;
        step(1, 1'b1);
        step(3);
        step(1, 1'b0, 1'b1);
        step(1, 1'b1);
        step(20);

        // Reset mid-HOLD.
        step(1, 1'b1);
        step(10);
        step(1, 1'b0, 1'b1);
        step(3);

        // Randomised soak.
        en_rand = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            step(1, ($urandom_range(0, 7) == 0), ($urandom_range(0, 299) == 0));
            if ($urandom_range(0, 15) == 0) repeat_mode = $urandom_range(0, 1);
            hold_ticks = HW'($urandom_range(0, 6));
        end
        repeat_mode = 1'b0;
        en_rand = 1'b0; en_per = 1;
        step(40);

        @(negedge clk);
        #1;
        check("go_count", 64'(dut_go), 64'(m_go));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
